// File: rtl/read_stream_stage.sv
// read_stream_stage: read-domain output stage of the CDC FIFO.
// It issues read enables against the empty flag and captures memory data
// one cycle after each accepted read. A two-entry skid buffer turns the
// FIFO read port into a first-word-fall-through valid/ready stream.
module read_stream_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic                  fifo_read_ack,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] slot0, slot1, slot0_nx, slot1_nx;
  logic [1:0]            count, count_nx;
  logic                  inflight;   // word acked last cycle, on fifo_read_data now
  logic                  pop;
  logic [2:0]            occ;        // words held or in flight after this cycle's pop

  assign out_valid = (count != 2'd0);
  assign out_data  = slot0;
  assign level     = count;
  assign pop       = out_valid & out_ready;

  // pop implies count >= 1, so this 3-bit sum never goes negative
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_read_enable = !fifo_empty && (occ < 3'd2);

  // Skid-buffer next state: push is the in-flight word landing this cycle
  always_comb begin
    slot0_nx = slot0;
    slot1_nx = slot1;
    count_nx = count;
    case ({inflight, pop})
      2'b01: begin
        slot0_nx = slot1;
        count_nx = count - 2'd1;
      end
      2'b10: begin
        if (count == 2'd0) slot0_nx = fifo_read_data;
        else               slot1_nx = fifo_read_data;
        count_nx = count + 2'd1;
      end
      2'b11: begin
        if (count == 2'd1) begin
          slot0_nx = fifo_read_data;
        end else begin
          slot0_nx = slot1;
          slot1_nx = fifo_read_data;
        end
      end
      default: ;
    endcase
  end

  // State register; reset discards buffered and in-flight words
  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      slot0    <= '0;
      slot1    <= '0;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      slot0    <= slot0_nx;
      slot1    <= slot1_nx;
      count    <= count_nx;
      inflight <= fifo_read_ack;
    end
  end

  // An ack while the buffer plus in-flight slot is already full would overflow
  a_no_overflow_ack: assert property (@(posedge read_clk) disable iff (read_rst)
    !(fifo_read_ack && (occ >= 3'd2)));

endmodule

// File: tb/tb_read_stream_stage.sv
// Directed and random-backpressure bench for read_stream_stage.
// A queue models the FIFO contents; memory data appears the cycle after an ack.
module tb_read_stream_stage;

  logic       read_clk = 1'b0;
  logic       read_rst;
  logic       fifo_empty;
  logic       fifo_read_enable;
  logic       fifo_read_ack;
  logic [7:0] fifo_read_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;
  int acks   = 0;
  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  bit force_empty = 1'b0;
  bit rdy = 1'b0;
  bit ack_seen;

  read_stream_stage #(.DATA_WIDTH(8)) dut (
    .read_clk         (read_clk),
    .read_rst         (read_rst),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_ack    (fifo_read_ack),
    .fifo_read_data   (fifo_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .level            (level)
  );

  // read control accepts a request whenever the FIFO is not empty
  assign fifo_read_ack = fifo_read_enable & ~fifo_empty;

  always #5 read_clk = ~read_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: sample ack before the edge, then present memory data
  // for an accepted read, update the registered empty flag and out_ready.
  task automatic step();
    @(negedge read_clk);
    ack_seen = fifo_read_ack;
    @(posedge read_clk);
    #1;
    if (ack_seen) begin
      fifo_read_data = src.pop_front();
      acks++;
    end else begin
      fifo_read_data = 8'hEE;
    end
    fifo_empty = force_empty || (src.size() == 0);
    out_ready  = rdy;
    #1;
  endtask

  initial begin
    int n, first, last;
    bit prev_hold;
    logic [7:0] prev_data;

    // reset then idle
    read_rst = 1'b1; fifo_empty = 1'b1; out_ready = 1'b0; fifo_read_data = 8'h00;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 2'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_en_empty", fifo_read_enable, 1'b0);
    fifo_empty = 1'b0;
    #1;
    chk("rst_en_nonempty", fifo_read_enable, 1'b1);
    fifo_empty = 1'b1;
    #10 read_rst = 1'b0;
    step();
    chk("idle_valid", out_valid, 1'b0);

    // single word 0xA5
    src.push_back(8'hA5); rdy = 1'b1;
    step();                                  // cycle C: ack
    chk("single_en", fifo_read_enable, 1'b1);
    step();                                  // C+1: data on bus
    chk("single_c1_valid", out_valid, 1'b0);
    step();                                  // C+2
    chk("single_c2_valid", out_valid, 1'b1);
    chk("single_c2_data", out_data, 8'hA5);
    chk("single_c2_level", level, 2'd1);
    step();                                  // C+3
    chk("single_c3_valid", out_valid, 1'b0);
    chk("single_c3_level", level, 2'd0);

    // streaming 16 words
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && n < 16; c++) begin
      step();
      if (out_valid) begin
        chk("stream_data", out_data, 8'(n));
        if (n == 0) first = c;
        last = c;
        n++;
      end
    end
    chk("stream_count", n, 16);
    chk("stream_no_gaps", last - first, 15);
    step();
    chk("stream_drained", out_valid, 1'b0);

    // stall with three words available
    rdy = 1'b0;
    src.push_back(8'h10); src.push_back(8'h11); src.push_back(8'h12);
    acks = 0;
    for (int i = 0; i < 6; i++) step();
    chk("stall_acks", acks, 2);
    chk("stall_level", level, 2'd2);
    chk("stall_en", fifo_read_enable, 1'b0);
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_data", out_data, 8'h10);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("unstall_valid", out_valid, 1'b1);
      chk("unstall_data", out_data, 8'(8'h10 + i));
    end
    step();
    chk("unstall_empty", out_valid, 1'b0);
    chk("unstall_level", level, 2'd0);

    // random back-pressure and empty flag, 1000 words
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      src.push_back(w);
      exp_q.push_back(w);
    end
    prev_hold = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 20000 && exp_q.size() != 0; c++) begin
      rdy = ($urandom_range(0, 2) != 0);
      force_empty = ($urandom_range(0, 3) == 0);
      step();
      chk("rand_level_max", level != 2'd3, 1'b1);
      if (prev_hold) begin
        chk("rand_hold_valid", out_valid, 1'b1);
        chk("rand_hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_extra_word", 1'b1, 1'b0);
        else chk("rand_data", out_data, exp_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
    chk("rand_all_seen", exp_q.size(), 0);
    force_empty = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rand_no_dup", out_valid, 1'b0);

    // reset with a word in flight
    rdy = 1'b0;
    src.push_back(8'h55); src.push_back(8'h66);
    step();                                  // ack for 0x55
    step();                                  // 0x55 on bus, in flight
    read_rst = 1'b1;
    #1;
    chk("inflight_rst_valid", out_valid, 1'b0);
    chk("inflight_rst_level", level, 2'd0);
    src.delete();
    fifo_empty = 1'b1;
    step();
    read_rst = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("inflight_discarded", out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
